// File: rtl/apb_inbuf_stream_port.sv
// rtl/apb_inbuf_stream_port.sv - APB slave: word FIFO push, token handshake, sliced input-buffer readback
// Optional irq_o output and CTRL[2] storage are enabled by defining APB_INBUF_IRQ_EN.

module apb_inbuf_stream_port #(
    parameter int BUS_AW          = 8,
    parameter int BUS_DW          = 32,
    parameter int MAX_CHANNEL_NUM = 128,
    parameter int DOUT_W          = 9,
    parameter int FIFO_DEPTH      = 16,
    parameter int TOKEN_W         = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic [BUS_AW-1:0]                 apb_paddr_s,
    input  logic                              apb_psel_s,
    input  logic                              apb_penable_s,
    input  logic                              apb_pwrite_s,
    input  logic [BUS_DW-1:0]                 apb_pwdata_s,
    output logic [BUS_DW-1:0]                 apb_prdata_s,
    output logic                              apb_pready_s,
    output logic                              apb_pslverr_s,
    output logic [BUS_DW-1:0]                 wd_data_o,
    output logic                              wd_vld_o,
    input  logic                              wd_rdy_i,
    output logic [TOKEN_W-1:0]                tok_id_o,
    output logic                              tok_vld_o,
    input  logic                              tok_rdy_i,
    input  logic [MAX_CHANNEL_NUM*DOUT_W-1:0] inbuf_dout_i,
    input  logic                              inbuf_dout_vld_i,
`ifdef APB_INBUF_IRQ_EN
    output logic                              irq_o,
`endif
    output logic                              inbuf_dout_rdy_o
);

    localparam int TOT_W      = MAX_CHANNEL_NUM * DOUT_W;
    localparam int NUM_SLICES = (TOT_W + BUS_DW - 1) / BUS_DW;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    localparam logic [BUS_AW-1:0] A_CTRL    = BUS_AW'(8'h00);
    localparam logic [BUS_AW-1:0] A_STATUS  = BUS_AW'(8'h04);
    localparam logic [BUS_AW-1:0] A_TOKEN   = BUS_AW'(8'h08);
    localparam logic [BUS_AW-1:0] A_WORD    = BUS_AW'(8'h0C);
    localparam logic [BUS_AW-1:0] A_INDEX   = BUS_AW'(8'h10);
    localparam logic [BUS_AW-1:0] A_PAYLOAD = BUS_AW'(8'h14);
    localparam logic [BUS_AW-1:0] A_RELEASE = BUS_AW'(8'h18);

    logic [2:0]         ctrl_q, ctrl_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               pend_q, pend_d;
    logic [TOKEN_W-1:0] tok_id_q, tok_id_d;
    logic               tok_vld_q, tok_vld_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [BUS_DW-1:0]  mem_q [FIFO_DEPTH];

    logic access, empty, full, pop, push, err_c, stall_c, ok;
    logic is_ctrl, is_status, is_token, is_word, is_index, is_payload, is_release;
    logic rel_c, wrap_c;
    logic [BUS_DW-1:0] rdata_c, status_c, slice_c;
    logic [NUM_SLICES*BUS_DW-1:0] padded_c;

    assign access     = apb_psel_s & apb_penable_s;
    assign empty      = (level_q == '0);
    assign full       = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop        = ~empty & wd_rdy_i;
    assign is_ctrl    = (apb_paddr_s == A_CTRL);
    assign is_status  = (apb_paddr_s == A_STATUS);
    assign is_token   = (apb_paddr_s == A_TOKEN);
    assign is_word    = (apb_paddr_s == A_WORD);
    assign is_index   = (apb_paddr_s == A_INDEX);
    assign is_payload = (apb_paddr_s == A_PAYLOAD);
    assign is_release = (apb_paddr_s == A_RELEASE);

    always_comb begin
        padded_c = '0;
        padded_c[TOT_W-1:0] = inbuf_dout_i;
        slice_c = padded_c[int'(idx_q)*BUS_DW +: BUS_DW];

        status_c = '0;
        status_c[0]    = inbuf_dout_vld_i;
        status_c[1]    = empty;
        status_c[2]    = full;
        status_c[3]    = err_q;
        status_c[4]    = tok_vld_q;
        status_c[15:8] = 8'(level_q);

        // Each register is legal in one direction only, except CTRL/STATUS/OUT_INDEX
        if (is_token || is_word || is_release)  err_c = ~apb_pwrite_s;
        else if (is_payload)                    err_c = apb_pwrite_s;
        else if (is_ctrl || is_status || is_index) err_c = 1'b0;
        else                                    err_c = 1'b1;

        stall_c = apb_pwrite_s & ((is_token & tok_vld_q & ~tok_rdy_i) |
                                  (is_word & full & ~pop));

        rdata_c = '0;
        if (is_ctrl)         rdata_c[2:0] = ctrl_q;
        else if (is_status)  rdata_c = status_c;
        else if (is_index)   rdata_c[IDX_W-1:0] = idx_q;
        else if (is_payload) rdata_c = slice_c;
    end

    assign apb_pready_s  = access & ~stall_c;
    assign apb_pslverr_s = access & err_c;
    assign apb_prdata_s  = (access & ~apb_pwrite_s & ~err_c) ? rdata_c : '0;
    assign ok            = access & ~stall_c & ~err_c;
    assign push          = ok & apb_pwrite_s & is_word;

    always_comb begin
        ctrl_d    = ctrl_q;
        err_d     = err_q | (access & err_c);
        idx_d     = idx_q;
        tok_id_d  = tok_id_q;
        tok_vld_d = tok_vld_q & ~tok_rdy_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        wrap_c    = 1'b0;

        if (ok && apb_pwrite_s && is_ctrl) begin
            ctrl_d[0] = apb_pwdata_s[0];
            ctrl_d[1] = apb_pwdata_s[1];
`ifdef APB_INBUF_IRQ_EN
            ctrl_d[2] = apb_pwdata_s[2];
`else
            ctrl_d[2] = 1'b0;
`endif
        end
        if (ok && apb_pwrite_s && is_status && apb_pwdata_s[3]) err_d = 1'b0;
        if (ok && apb_pwrite_s && is_token) begin
            tok_id_d  = apb_pwdata_s[TOKEN_W-1:0];
            tok_vld_d = 1'b1;
        end

        if (ok && apb_pwrite_s && is_index) begin
            if (apb_pwdata_s >= BUS_DW'(NUM_SLICES)) idx_d = IDX_W'(NUM_SLICES - 1);
            else                                     idx_d = apb_pwdata_s[IDX_W-1:0];
        end else if (ok && !apb_pwrite_s && is_payload && ctrl_q[0]) begin
            if (idx_q == IDX_W'(NUM_SLICES - 1)) begin
                idx_d  = '0;
                wrap_c = ctrl_q[1];
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Flush wins over a concurrent pop; no push can coincide with a CTRL write
        if (ok && apb_pwrite_s && is_ctrl && apb_pwdata_s[3]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    assign rel_c = (ok & apb_pwrite_s & is_release) | wrap_c;

    always_comb begin
        pend_d = pend_q;
        if (pend_q && inbuf_dout_vld_i) pend_d = 1'b0;
        if (rel_c)                      pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q    <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            tok_id_q  <= '0;
            tok_vld_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            tok_id_q  <= tok_id_d;
            tok_vld_q <= tok_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= apb_pwdata_s;
    end

`ifdef APB_INBUF_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) irq_q <= 1'b0;
        else          irq_q <= ctrl_q[2] & inbuf_dout_vld_i & ~pend_q;
    end
    assign irq_o = irq_q;
`endif

    assign wd_vld_o         = ~empty;
    assign wd_data_o        = empty ? '0 : mem_q[rd_ptr_q];
    assign tok_id_o         = tok_id_q;
    assign tok_vld_o        = tok_vld_q;
    assign inbuf_dout_rdy_o = pend_q;

endmodule

// File: tb/tb_apb_inbuf_stream_port.sv
// tb/tb_apb_inbuf_stream_port.sv - directed self-checking bench for apb_inbuf_stream_port
module tb_apb_inbuf_stream_port;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata, prdata;
    logic         pready, pslverr;
    logic [31:0]  wd_data;
    logic         wd_vld, wd_rdy;
    logic [4:0]   tok_id;
    logic         tok_vld, tok_rdy;
    logic [1151:0] dout;
    logic         dout_vld, dout_rdy;
`ifdef APB_INBUF_IRQ_EN
    logic         irq;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_inbuf_stream_port dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .apb_paddr_s(paddr), .apb_psel_s(psel), .apb_penable_s(penable),
        .apb_pwrite_s(pwrite), .apb_pwdata_s(pwdata), .apb_prdata_s(prdata),
        .apb_pready_s(pready), .apb_pslverr_s(pslverr),
        .wd_data_o(wd_data), .wd_vld_o(wd_vld), .wd_rdy_i(wd_rdy),
        .tok_id_o(tok_id), .tok_vld_o(tok_vld), .tok_rdy_i(tok_rdy),
        .inbuf_dout_i(dout), .inbuf_dout_vld_i(dout_vld),
`ifdef APB_INBUF_IRQ_EN
        .irq_o(irq),
`endif
        .inbuf_dout_rdy_o(dout_rdy)
    );

    task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        bit done = 0;
        @(posedge clk); #1;
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1;
        rd = 'x; err = 1'bx;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (pready) begin
                rd = prdata; err = pslverr; done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL apb_timeout addr %h got pready 0 exp 1", a);
        end
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e;
        rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        wd_rdy = 0; tok_rdy = 0; dout = '0; dout_vld = 0;
        #23;
        checks++;
        if ({prdata, pready, pslverr, wd_data, wd_vld, tok_id, tok_vld, dout_rdy} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0",
                {prdata, pready, pslverr, wd_data, wd_vld, tok_id, tok_vld, dout_rdy});
        end
        @(posedge clk); #1 rst_n = 1;
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp 2", rd); end
        apb(0, 8'h00, 0, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
        apb(0, 8'h10, 0, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_index got %h exp 0", rd); end
    endtask

    task automatic test_fifo_backpressure();
        logic [31:0] rd; logic e;
        int n = 0;
        wd_rdy = 0;
        for (int i = 1; i <= 16; i++) apb(1, 8'h0C, 32'(i), rd, e);
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h1004) begin errors++; $display("FAIL fifo_full_status got %h exp 1004", rd); end
        fork
            apb(1, 8'h0C, 32'd17, rd, e);
            begin
                repeat (4) @(negedge clk);
                checks++; if (pready !== 1'b0) begin errors++; $display("FAIL fifo_full_stall got %b exp 0", pready); end
                @(posedge clk); #2 wd_rdy = 1;
                #1;
                checks++; if (pready !== 1'b1) begin errors++; $display("FAIL fifo_pop_space got %b exp 1", pready); end
                for (int k = 0; k < 60 && n < 17; k++) begin
                    @(negedge clk);
                    if (wd_vld && wd_rdy) begin
                        checks++;
                        if (wd_data !== 32'(n + 1)) begin
                            errors++; $display("FAIL fifo_order got %0d exp %0d", wd_data, n + 1);
                        end
                        n++;
                    end
                end
                checks++; if (n != 17) begin errors++; $display("FAIL fifo_pop_count got %0d exp 17", n); end
                @(posedge clk); #1 wd_rdy = 0;
            end
        join
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL fifo_drained got %h exp 2", rd); end
    endtask

    task automatic test_payload();
        logic [31:0] rd, exp; logic e;
        for (int k = 0; k < 144; k++) dout[k*8 +: 8] = 8'(k);
        dout_vld = 0;
        apb(1, 8'h10, 0, rd, e);
        apb(1, 8'h00, 32'h3, rd, e);
        for (int i = 0; i < 36; i++) begin
            exp = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            if (i == 35) begin
                checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL release_early got %b exp 0", dout_rdy); end
            end
            apb(0, 8'h14, 0, rd, e);
            checks++; if (rd !== exp) begin errors++; $display("FAIL payload_%0d got %h exp %h", i, rd, exp); end
        end
        checks++; if (dout_rdy !== 1'b1) begin errors++; $display("FAIL auto_release got %b exp 1", dout_rdy); end
        dout_vld = 1;
        @(posedge clk); #1;
        checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL release_clear got %b exp 0", dout_rdy); end
        dout_vld = 0;
        apb(0, 8'h10, 0, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL index_wrap got %h exp 0", rd); end
        apb(1, 8'h00, 32'h0, rd, e);
        apb(1, 8'h10, 32'd50, rd, e);
        apb(0, 8'h10, 0, rd, e);
        checks++; if (rd !== 32'd35) begin errors++; $display("FAIL index_clamp got %0d exp 35", rd); end
        apb(0, 8'h14, 0, rd, e);
        checks++; if (rd !== 32'h8F8E8D8C) begin errors++; $display("FAIL payload_top got %h exp 8f8e8d8c", rd); end
        apb(0, 8'h10, 0, rd, e);
        checks++; if (rd !== 32'd35) begin errors++; $display("FAIL index_no_inc got %0d exp 35", rd); end
    endtask

    task automatic test_token();
        logic [31:0] rd; logic e;
        tok_rdy = 0;
        apb(1, 8'h08, 32'h05, rd, e);
        checks++; if ({tok_vld, tok_id} !== {1'b1, 5'h05}) begin errors++; $display("FAIL token_first got %h exp 25", {tok_vld, tok_id}); end
        fork
            apb(1, 8'h08, 32'h1A, rd, e);
            begin
                repeat (4) @(negedge clk);
                checks++; if (pready !== 1'b0) begin errors++; $display("FAIL token_stall got %b exp 0", pready); end
                @(posedge clk); #2 tok_rdy = 1;
                @(negedge clk);
                checks++; if (tok_id !== 5'h05) begin errors++; $display("FAIL token_id0 got %h exp 05", tok_id); end
                @(negedge clk);
                checks++; if ({tok_vld, tok_id} !== {1'b1, 5'h1A}) begin errors++; $display("FAIL token_id1 got %h exp 3a", {tok_vld, tok_id}); end
                @(negedge clk);
                checks++; if (tok_vld !== 1'b0) begin errors++; $display("FAIL token_drain got %b exp 0", tok_vld); end
                tok_rdy = 0;
            end
        join
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e;
        apb(0, 8'h3C, 0, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmapped_slverr got %b exp 1", e); end
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'hA) begin errors++; $display("FAIL err_sticky got %h exp a", rd); end
        apb(1, 8'h04, 32'h8, rd, e);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL status_wr_ok got %b exp 0", e); end
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_clear got %h exp 2", rd); end
        apb(1, 8'h14, 32'h1, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL write_ro got %b exp 1", e); end
        apb(0, 8'h0C, 0, rd, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL read_wo got %b exp 1", e); end
        apb(1, 8'h04, 32'h8, rd, e);
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_no_side_effect got %h exp 2", rd); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic e;
        wd_rdy = 0;
        for (int i = 0; i < 5; i++) apb(1, 8'h0C, 32'hA0 + 32'(i), rd, e);
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h0500) begin errors++; $display("FAIL flush_pre_level got %h exp 500", rd); end
        apb(1, 8'h00, 32'h8, rd, e);
        checks++; if (wd_vld !== 1'b0) begin errors++; $display("FAIL flush_vld got %b exp 0", wd_vld); end
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL flush_status got %h exp 2", rd); end
        apb(0, 8'h00, 0, rd, e);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush_reads0 got %h exp 0", rd); end
    endtask

    task automatic test_back_to_back_release();
        logic [31:0] rd; logic e;
        dout_vld = 0;
        apb(1, 8'h18, 0, rd, e);
        apb(1, 8'h18, 0, rd, e);
        checks++; if (dout_rdy !== 1'b1) begin errors++; $display("FAIL release_set got %b exp 1", dout_rdy); end
        dout_vld = 1;
        @(posedge clk); #1;
        checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL release_once got %b exp 0", dout_rdy); end
        @(posedge clk); #1;
        checks++; if (dout_rdy !== 1'b0) begin errors++; $display("FAIL release_absorbed got %b exp 0", dout_rdy); end
        dout_vld = 0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd; logic e;
        wd_rdy = 0; tok_rdy = 0; dout_vld = 0;
        for (int i = 0; i < 3; i++) apb(1, 8'h0C, 32'(i), rd, e);
        apb(1, 8'h08, 32'h07, rd, e);
        apb(1, 8'h18, 0, rd, e);
        checks++; if ({wd_vld, tok_vld, dout_rdy} !== 3'b111) begin errors++; $display("FAIL midflight_pre got %b exp 111", {wd_vld, tok_vld, dout_rdy}); end
        #3 rst_n = 0;
        #3;
        checks++; if ({wd_vld, tok_vld, dout_rdy, tok_id} !== '0) begin errors++; $display("FAIL midflight_drop got %h exp 0", {wd_vld, tok_vld, dout_rdy, tok_id}); end
        @(posedge clk); #1 rst_n = 1;
        apb(0, 8'h04, 0, rd, e);
        checks++; if (rd !== 32'h2) begin errors++; $display("FAIL midflight_status got %h exp 2", rd); end
    endtask

    initial begin
        test_reset();
        test_fifo_backpressure();
        test_payload();
        test_token();
        test_errors();
        test_flush();
        test_back_to_back_release();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
